// File: rtl/sopc_cpu_oci_dct_packer.sv
// Trace symbol packer: collects 2-bit symbols LSB-first into 15-symbol words
// and flushes any partial word when the trace session is ended.
module sopc_cpu_oci_dct_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  sym_in,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic        end_req,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        dct_valid,
    input  logic        dct_ready,
    output logic        test_ending,
    output logic        test_has_ended
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_SLOT = 4'd14;
    localparam logic [3:0] FULL_CNT  = 4'd15;

    state_t      state, state_nxt;
    logic [29:0] acc, acc_nxt, acc_ins;
    logic [3:0]  cnt, cnt_nxt;
    logic [29:0] out_buf, out_buf_nxt;
    logic [3:0]  out_cnt, out_cnt_nxt;
    logic        out_vld, out_vld_nxt;
    logic        out_free;
    logic        sym_xfer;
    logic [4:0]  shamt;

    always_comb begin
        out_free = !out_vld || dct_ready;
        shamt    = {cnt, 1'b0};
        acc_ins  = (acc & ~(30'h3 << shamt)) | ({28'd0, sym_in} << shamt);

        // The last slot can only be filled if the completed word has somewhere to go.
        sym_ready = (state == RUN) && ((cnt != LAST_SLOT) || out_free);
        sym_xfer  = sym_valid && sym_ready;

        state_nxt   = state;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        out_buf_nxt = out_buf;
        out_cnt_nxt = out_cnt;
        out_vld_nxt = out_vld;

        if (out_vld && dct_ready) begin
            out_vld_nxt = 1'b0;
        end

        case (state)
            RUN: begin
                if (sym_xfer) begin
                    if (cnt == LAST_SLOT) begin
                        out_buf_nxt = acc_ins;
                        out_cnt_nxt = FULL_CNT;
                        out_vld_nxt = 1'b1;
                        acc_nxt     = '0;
                        cnt_nxt     = '0;
                    end else begin
                        acc_nxt = acc_ins;
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                if (end_req) begin
                    state_nxt = FLUSH;
                end
            end

            FLUSH: begin
                if (cnt != 4'd0) begin
                    if (out_free) begin
                        out_buf_nxt = acc;
                        out_cnt_nxt = cnt;
                        out_vld_nxt = 1'b1;
                        acc_nxt     = '0;
                        cnt_nxt     = '0;
                    end
                end else if (out_free) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                state_nxt = DONE;
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= RUN;
            acc     <= '0;
            cnt     <= '0;
            out_buf <= '0;
            out_cnt <= '0;
            out_vld <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            out_buf <= out_buf_nxt;
            out_cnt <= out_cnt_nxt;
            out_vld <= out_vld_nxt;
        end
    end

    assign dct_buffer     = out_buf;
    assign dct_count      = out_cnt;
    assign dct_valid      = out_vld;
    assign test_ending    = (state != RUN);
    assign test_has_ended = (state == DONE);

endmodule

// File: tb/tb_sopc_cpu_oci_dct_packer.sv
// Bench for the trace symbol packer: directed scenarios plus randomized
// sessions scored against a queue-based model of the packing rules.
module tb_sopc_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  sym_in = 2'd0;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic        end_req = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready = 1'b0;
    logic        test_ending;
    logic        test_has_ended;

    int checks = 0;
    int errors = 0;

    logic [1:0]  part_q[$];
    logic [29:0] exp_buf_q[$];
    logic [3:0]  exp_cnt_q[$];

    sopc_cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sym_in         (sym_in),
        .sym_valid      (sym_valid),
        .sym_ready      (sym_ready),
        .end_req        (end_req),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Word value = sum of symbol k times 4^k.
    function automatic logic [29:0] pack_part();
        longint w = 0;
        foreach (part_q[k]) w += longint'(part_q[k]) << (2 * k);
        return w[29:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; sym_valid = 1'b0; end_req = 1'b0; dct_ready = 1'b0; sym_in = 2'd0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if ({dct_buffer, dct_count, dct_valid, test_ending, test_has_ended} !== 37'd0 || sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: buf=%h cnt=%0d vld=%b end=%b ended=%b rdy=%b, required all 0 and rdy=1",
                     dct_buffer, dct_count, dct_valid, test_ending, test_has_ended, sym_ready);
        end
    endtask

    task automatic test_full_word();
        do_reset();
        dct_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            sym_valid = 1'b1; sym_in = 2'b01;
            #1;
            checks++;
            if (sym_ready !== 1'b1 || dct_valid !== 1'b0) begin
                errors++;
                $display("FAIL full_word_feed[%0d]: rdy=%b vld=%b, required rdy=1 vld=0", i, sym_ready, dct_valid);
            end
            @(negedge clk);
        end
        sym_valid = 1'b0;
        #1;
        checks++;
        if (dct_valid !== 1'b1 || dct_buffer !== 30'h15555555 || dct_count !== 4'd15) begin
            errors++;
            $display("FAIL full_word_out: vld=%b buf=%h cnt=%0d, required 1 15555555 15", dct_valid, dct_buffer, dct_count);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dct_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_word_one_cycle: vld=%b, required 0", dct_valid);
        end
    endtask

    task automatic test_partial_flush();
        logic [1:0] seq [3];
        seq[0] = 2'd3; seq[1] = 2'd2; seq[2] = 2'd1;
        do_reset();
        dct_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sym_valid = 1'b1; sym_in = seq[i];
            @(negedge clk);
        end
        sym_valid = 1'b0; end_req = 1'b1;
        #1;
        checks++;
        if (test_ending !== 1'b0) begin
            errors++;
            $display("FAIL partial_pre_end: ending=%b, required 0", test_ending);
        end
        @(negedge clk);
        end_req = 1'b0;
        #1;
        checks++;
        if (test_ending !== 1'b1 || test_has_ended !== 1'b0 || dct_valid !== 1'b0) begin
            errors++;
            $display("FAIL partial_flush_enter: ending=%b ended=%b vld=%b, required 1 0 0", test_ending, test_has_ended, dct_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dct_valid !== 1'b1 || dct_buffer !== 30'h0000001B || dct_count !== 4'd3 || test_has_ended !== 1'b0) begin
            errors++;
            $display("FAIL partial_word: vld=%b buf=%h cnt=%0d ended=%b, required 1 0000001b 3 0",
                     dct_valid, dct_buffer, dct_count, test_has_ended);
        end
        @(negedge clk);
        #1;
        checks++;
        if (test_has_ended !== 1'b1 || dct_valid !== 1'b0) begin
            errors++;
            $display("FAIL partial_done: ended=%b vld=%b, required 1 0", test_has_ended, dct_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [29:0] w1, w2;
        do_reset();
        dct_ready = 1'b0;
        part_q.delete();
        for (int i = 0; i < 15; i++) begin
            sym_valid = 1'b1; sym_in = 2'($urandom);
            part_q.push_back(sym_in);
            @(negedge clk);
        end
        w1 = pack_part();
        part_q.delete();
        for (int i = 0; i < 14; i++) begin
            sym_in = 2'($urandom);
            part_q.push_back(sym_in);
            #1;
            checks++;
            if (sym_ready !== 1'b1 || dct_valid !== 1'b1 || dct_buffer !== w1 || dct_count !== 4'd15) begin
                errors++;
                $display("FAIL bp_fill[%0d]: rdy=%b vld=%b buf=%h cnt=%0d, required 1 1 %h 15",
                         i, sym_ready, dct_valid, dct_buffer, dct_count, w1);
            end
            @(negedge clk);
        end
        sym_in = 2'($urandom);
        part_q.push_back(sym_in);
        w2 = pack_part();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (sym_ready !== 1'b0 || dct_valid !== 1'b1 || dct_buffer !== w1 || dct_count !== 4'd15) begin
                errors++;
                $display("FAIL bp_stall[%0d]: rdy=%b vld=%b buf=%h cnt=%0d, required 0 1 %h 15",
                         i, sym_ready, dct_valid, dct_buffer, dct_count, w1);
            end
            @(negedge clk);
        end
        dct_ready = 1'b1;
        #1;
        checks++;
        if (sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_rdy: rdy=%b, required 1", sym_ready);
        end
        @(negedge clk);
        sym_valid = 1'b0;
        #1;
        checks++;
        if (dct_valid !== 1'b1 || dct_buffer !== w2 || dct_count !== 4'd15) begin
            errors++;
            $display("FAIL bp_second_word: vld=%b buf=%h cnt=%0d, required 1 %h 15", dct_valid, dct_buffer, dct_count, w2);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dct_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: vld=%b, required 0", dct_valid);
        end
    endtask

    task automatic test_empty_session();
        do_reset();
        dct_ready = 1'b1;
        end_req = 1'b1;
        @(negedge clk);
        end_req = 1'b0;
        #1;
        checks++;
        if (test_ending !== 1'b1 || dct_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_ending: ending=%b vld=%b, required 1 0", test_ending, dct_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (test_has_ended !== 1'b1 || dct_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: ended=%b vld=%b, required 1 0", test_has_ended, dct_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sym_valid = 1'b1; sym_in = 2'd3; end_req = 1'b1;
            #1;
            checks++;
            if (sym_ready !== 1'b0 || dct_valid !== 1'b0 || test_has_ended !== 1'b1) begin
                errors++;
                $display("FAIL empty_ignore[%0d]: rdy=%b vld=%b ended=%b, required 0 0 1", i, sym_ready, dct_valid, test_has_ended);
            end
        end
        sym_valid = 1'b0; end_req = 1'b0;
    endtask

    task automatic test_end_on_last();
        logic [29:0] w;
        do_reset();
        dct_ready = 1'b1;
        part_q.delete();
        for (int i = 0; i < 15; i++) begin
            sym_valid = 1'b1; sym_in = 2'($urandom);
            end_req = (i == 14);
            part_q.push_back(sym_in);
            @(negedge clk);
        end
        w = pack_part();
        sym_valid = 1'b0; end_req = 1'b0;
        #1;
        checks++;
        if (dct_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== w || test_ending !== 1'b1) begin
            errors++;
            $display("FAIL last_word: vld=%b cnt=%0d buf=%h ending=%b, required 1 15 %h 1",
                     dct_valid, dct_count, dct_buffer, test_ending, w);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (test_has_ended !== 1'b1 || dct_valid !== 1'b0) begin
                errors++;
                $display("FAIL last_done[%0d]: ended=%b vld=%b, required 1 0", i, test_has_ended, dct_valid);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        dct_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sym_valid = 1'b1; sym_in = 2'd3;
            @(negedge clk);
        end
        sym_valid = 1'b0; end_req = 1'b1;
        @(negedge clk);
        end_req = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (dct_valid !== 1'b1 || dct_count !== 4'd3 || test_ending !== 1'b1) begin
            errors++;
            $display("FAIL rst_pending: vld=%b cnt=%0d ending=%b, required 1 3 1", dct_valid, dct_count, test_ending);
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if ({dct_buffer, dct_count, dct_valid, test_ending, test_has_ended} !== 37'd0 || sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_flush: buf=%h cnt=%0d vld=%b end=%b ended=%b rdy=%b, required all 0 and rdy=1",
                     dct_buffer, dct_count, dct_valid, test_ending, test_has_ended, sym_ready);
        end
        dct_ready = 1'b1;
        sym_valid = 1'b1; sym_in = 2'd2;
        @(negedge clk);
        sym_valid = 1'b0; end_req = 1'b1;
        @(negedge clk);
        end_req = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (dct_valid !== 1'b1 || dct_buffer !== 30'h2 || dct_count !== 4'd1) begin
            errors++;
            $display("FAIL rst_new_session: vld=%b buf=%h cnt=%0d, required 1 00000002 1", dct_valid, dct_buffer, dct_count);
        end
    endtask

    task automatic test_random();
        for (int sess = 0; sess < 4; sess++) begin
            bit          in_run, ending_exp, done, exp_rdy, prev_stall;
            logic [29:0] prev_buf;
            logic [3:0]  prev_cnt;
            int          end_at;
            do_reset();
            part_q.delete(); exp_buf_q.delete(); exp_cnt_q.delete();
            in_run = 1'b1; ending_exp = 1'b0; done = 1'b0; prev_stall = 1'b0;
            prev_buf = '0; prev_cnt = '0;
            end_at = int'($urandom_range(150, 20));
            for (int n = 0; n < 800 && !done; n++) begin
                sym_valid = ($urandom % 4) != 0;
                sym_in    = 2'($urandom);
                dct_ready = ($urandom % 3) != 0;
                end_req   = (n >= end_at) && (($urandom % 4) == 0);
                #1;
                exp_rdy = in_run && !(part_q.size() == 14 && dct_valid && !dct_ready);
                checks++;
                if (sym_ready !== exp_rdy || test_ending !== ending_exp) begin
                    errors++;
                    $display("FAIL rand_ctrl s%0d c%0d: rdy=%b ending=%b, required %b %b",
                             sess, n, sym_ready, test_ending, exp_rdy, ending_exp);
                end
                if (prev_stall) begin
                    checks++;
                    if (dct_valid !== 1'b1 || dct_buffer !== prev_buf || dct_count !== prev_cnt) begin
                        errors++;
                        $display("FAIL rand_stable s%0d c%0d: vld=%b buf=%h cnt=%0d, required 1 %h %0d",
                                 sess, n, dct_valid, dct_buffer, dct_count, prev_buf, prev_cnt);
                    end
                end
                if (dct_valid === 1'b1 && dct_ready) begin
                    checks++;
                    if (exp_buf_q.size() == 0) begin
                        errors++;
                        $display("FAIL rand_extra_word s%0d c%0d: buf=%h cnt=%0d, required no word", sess, n, dct_buffer, dct_count);
                    end else begin
                        logic [29:0] eb;
                        logic [3:0]  ec;
                        eb = exp_buf_q.pop_front();
                        ec = exp_cnt_q.pop_front();
                        if (dct_buffer !== eb || dct_count !== ec) begin
                            errors++;
                            $display("FAIL rand_word s%0d c%0d: buf=%h cnt=%0d, required %h %0d",
                                     sess, n, dct_buffer, dct_count, eb, ec);
                        end
                    end
                end
                if (test_has_ended === 1'b1) begin
                    checks++;
                    if (in_run || exp_buf_q.size() != 0 || dct_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_done s%0d c%0d: in_run=%b words_left=%0d vld=%b, required 0 0 0",
                                 sess, n, in_run, exp_buf_q.size(), dct_valid);
                    end
                    done = 1'b1;
                end
                prev_stall = dct_valid && !dct_ready;
                prev_buf   = dct_buffer;
                prev_cnt   = dct_count;
                if (sym_valid && exp_rdy) begin
                    part_q.push_back(sym_in);
                    if (part_q.size() == 15) begin
                        exp_buf_q.push_back(pack_part());
                        exp_cnt_q.push_back(4'd15);
                        part_q.delete();
                    end
                end
                if (in_run && end_req) begin
                    in_run = 1'b0;
                    if (part_q.size() != 0) begin
                        exp_buf_q.push_back(pack_part());
                        exp_cnt_q.push_back(4'(part_q.size()));
                        part_q.delete();
                    end
                end
                ending_exp = !in_run;
                @(negedge clk);
            end
            if (!done) begin
                errors++;
                $display("FAIL rand_timeout s%0d: session did not end within budget", sess);
            end
        end
        sym_valid = 1'b0; end_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial_flush();
        test_backpressure();
        test_empty_session();
        test_end_on_last();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
